// File: rtl/rv32v_memory_arbiter.sv
// rv32v_memory_arbiter
//   Shares the single data-memory port between the scalar pipeline and the
//   vector lane-group memory unit. When both request in the same cycle, the
//   requester whose completion-buffer entry is oldest (closest to the CB tail)
//   wins, which keeps memory side effects in program order across the cores.
//   A grant is held for the whole bus transaction. Every grant is followed by
//   at least one IDLE cycle, so the other requester is always re-evaluated.
//
// Ports
//   CLK, nRST            clock (rising edge) / asynchronous active-low reset
//   v_ena                vector unit enabled; vector requests ignored when 0
//   cb_tail_index        index of the oldest CB entry
//   scalar_cb_index      CB index of the scalar memory op
//   vector_cb_index      CB index of the vector memory op
//   s_* / v_*            requester side: ren, wen, addr, wdata, byte_en in;
//                        rdata, busy out (busy = 0 means complete this cycle)
//   mem_*                dcache-side bus: ren, wen, addr, wdata, byte_en out;
//                        rdata, busy in
//   grant_owner          00 none, 01 scalar, 10 vector
module rv32v_memory_arbiter #(
   parameter int NUM_CB_ENTRY = 16,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32
) (
   input  logic                            CLK,
   input  logic                            nRST,
   input  logic                            v_ena,
   input  logic [$clog2(NUM_CB_ENTRY)-1:0] cb_tail_index,
   input  logic [$clog2(NUM_CB_ENTRY)-1:0] scalar_cb_index,
   input  logic [$clog2(NUM_CB_ENTRY)-1:0] vector_cb_index,
   input  logic                            s_ren,
   input  logic                            s_wen,
   input  logic [ADDR_W-1:0]               s_addr,
   input  logic [DATA_W-1:0]               s_wdata,
   input  logic [3:0]                      s_byte_en,
   output logic [DATA_W-1:0]               s_rdata,
   output logic                            s_busy,
   input  logic                            v_ren,
   input  logic                            v_wen,
   input  logic [ADDR_W-1:0]               v_addr,
   input  logic [DATA_W-1:0]               v_wdata,
   input  logic [3:0]                      v_byte_en,
   output logic [DATA_W-1:0]               v_rdata,
   output logic                            v_busy,
   output logic                            mem_ren,
   output logic                            mem_wen,
   output logic [ADDR_W-1:0]               mem_addr,
   output logic [DATA_W-1:0]               mem_wdata,
   output logic [3:0]                      mem_byte_en,
   input  logic [DATA_W-1:0]               mem_rdata,
   input  logic                            mem_busy,
   output logic [1:0]                      grant_owner
);

   localparam int CBW = $clog2(NUM_CB_ENTRY);

   // Encoding doubles as the grant_owner code, so the owner output comes
   // straight from the state register.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT_S = 2'b01,
      GRANT_V = 2'b10
   } state_t;

   state_t state;

   logic s_req;
   logic v_req;
   logic [CBW-1:0] age_s;
   logic [CBW-1:0] age_v;

   assign s_req = s_ren | s_wen;
   assign v_req = v_ena & (v_ren | v_wen);

   // Distance from the tail, modulo the CB depth: smaller means older.
   assign age_s = scalar_cb_index - cb_tail_index;
   assign age_v = vector_cb_index - cb_tail_index;

   // Equal ages cannot legally occur; the scalar side takes the tie.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (s_req && (!v_req || (age_s <= age_v)))
                  state <= GRANT_S;
               else if (v_req)
                  state <= GRANT_V;
            end
            // Completion or abort (request withdrawn) both release the bus.
            GRANT_S: if (!mem_busy || !s_req) state <= IDLE;
            GRANT_V: if (!mem_busy || !v_req) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign grant_owner = state;

   // The owner's request is forwarded combinationally so an abort pulls
   // mem_ren/mem_wen low in the same cycle it happens.
   always_comb begin
      mem_ren     = 1'b0;
      mem_wen     = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_byte_en = '0;
      s_rdata     = '0;
      v_rdata     = '0;
      s_busy      = 1'b1;
      v_busy      = 1'b1;
      case (state)
         GRANT_S: begin
            mem_ren     = s_ren;
            mem_wen     = s_wen;
            mem_addr    = s_addr;
            mem_wdata   = s_wdata;
            mem_byte_en = s_byte_en;
            s_rdata     = mem_rdata;
            s_busy      = mem_busy;
         end
         GRANT_V: begin
            // v_ena falling mid-grant acts as an abort on the bus.
            mem_ren     = v_ena & v_ren;
            mem_wen     = v_ena & v_wen;
            mem_addr    = v_addr;
            mem_wdata   = v_wdata;
            mem_byte_en = v_byte_en;
            v_rdata     = mem_rdata;
            v_busy      = mem_busy;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rv32v_memory_arbiter.sv
// Self-checking bench for rv32v_memory_arbiter: directed arbitration table,
// hand-written multi-cycle sequences, then randomized traffic against a
// behavioural model of who owns the bus.
module tb_rv32v_memory_arbiter;
   localparam int N   = 16;
   localparam int CBW = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;

   logic           CLK = 1'b0;
   logic           nRST = 1'b0;
   logic           v_ena;
   logic [CBW-1:0] cb_tail_index, scalar_cb_index, vector_cb_index;
   logic           s_ren, s_wen, v_ren, v_wen;
   logic [AW-1:0]  s_addr, v_addr, mem_addr;
   logic [DW-1:0]  s_wdata, v_wdata, s_rdata, v_rdata, mem_wdata, mem_rdata;
   logic [3:0]     s_byte_en, v_byte_en, mem_byte_en;
   logic           s_busy, v_busy, mem_ren, mem_wen, mem_busy;
   logic [1:0]     grant_owner;

   rv32v_memory_arbiter #(.NUM_CB_ENTRY(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK(CLK), .nRST(nRST), .v_ena(v_ena),
      .cb_tail_index(cb_tail_index), .scalar_cb_index(scalar_cb_index),
      .vector_cb_index(vector_cb_index),
      .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_byte_en(s_byte_en), .s_rdata(s_rdata), .s_busy(s_busy),
      .v_ren(v_ren), .v_wen(v_wen), .v_addr(v_addr), .v_wdata(v_wdata),
      .v_byte_en(v_byte_en), .v_rdata(v_rdata), .v_busy(v_busy),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
      .mem_rdata(mem_rdata), .mem_busy(mem_busy), .grant_owner(grant_owner)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int m_owner = 0;   // model: 0 none, 1 scalar, 2 vector

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int age(input int idx, input int tail);
      return (idx - tail + N) % N;
   endfunction

   // Expected outputs follow from who owns the bus and the current inputs.
   task automatic check_outputs();
      logic e_ren, e_wen, e_sb, e_vb;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd, e_sr, e_vr;
      logic [3:0] e_be;
      e_ren = 0; e_wen = 0; e_addr = 0; e_wd = 0; e_be = 0;
      e_sr = 0; e_vr = 0; e_sb = 1; e_vb = 1;
      if (m_owner == 1) begin
         e_ren = s_ren; e_wen = s_wen; e_addr = s_addr; e_wd = s_wdata; e_be = s_byte_en;
         e_sr = mem_rdata; e_sb = mem_busy;
      end else if (m_owner == 2) begin
         e_ren = v_ena && v_ren; e_wen = v_ena && v_wen; e_addr = v_addr;
         e_wd = v_wdata; e_be = v_byte_en; e_vr = mem_rdata; e_vb = mem_busy;
      end
      chk("grant_owner", grant_owner, m_owner);
      chk("mem_ctl", {mem_ren, mem_wen, mem_byte_en}, {e_ren, e_wen, e_be});
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("s_resp", {s_busy, s_rdata}, {e_sb, e_sr});
      chk("v_resp", {v_busy, v_rdata}, {e_vb, e_vr});
   endtask

   task automatic model_next();
      bit sq, vq;
      int as, av;
      sq = s_ren || s_wen;
      vq = v_ena && (v_ren || v_wen);
      if (!nRST) m_owner = 0;
      else if (m_owner == 0) begin
         as = age(scalar_cb_index, cb_tail_index);
         av = age(vector_cb_index, cb_tail_index);
         if (sq && vq) m_owner = (av < as) ? 2 : 1;
         else if (sq) m_owner = 1;
         else if (vq) m_owner = 2;
      end else if (m_owner == 1) begin
         if (!mem_busy || !sq) m_owner = 0;
      end else begin
         if (!mem_busy || !vq) m_owner = 0;
      end
   endtask

   // One clock: check at the falling edge, advance the model, then return
   // 1 time unit after the rising edge where the next inputs are driven.
   task automatic tick();
      @(negedge CLK);
      check_outputs();
      model_next();
      @(posedge CLK);
      #1;
   endtask

   task automatic quiet();
      v_ena = 1; s_ren = 0; s_wen = 0; v_ren = 0; v_wen = 0;
      cb_tail_index = 0; scalar_cb_index = 0; vector_cb_index = 0;
      s_addr = 0; v_addr = 0; s_wdata = 0; v_wdata = 0;
      s_byte_en = 0; v_byte_en = 0; mem_rdata = 0; mem_busy = 1;
   endtask

   typedef struct {
      logic [3:0] tail, sidx, vidx;
      logic sr, sw, vr, vw, ve;
      logic [1:0] exp;
   } vec_t;
   vec_t tbl[9];

   initial begin
      int idle;
      quiet();
      // Reset state
      #2;
      chk("rst_owner", grant_owner, 2'b00);
      chk("rst_busy", {s_busy, v_busy, mem_ren, mem_wen}, 4'b1100);
      @(posedge CLK); #1;
      nRST = 1;
      tick();

      // Arbitration table: winner seen one cycle after the request.
      tbl[0] = '{4'd0,  4'd2, 4'd1,  1,0,0,0,1, 2'b01}; // scalar only
      tbl[1] = '{4'd0,  4'd2, 4'd1,  0,0,0,1,1, 2'b10}; // vector only
      tbl[2] = '{4'd3,  4'd6, 4'd4,  1,0,1,0,1, 2'b10}; // vector older
      tbl[3] = '{4'd3,  4'd4, 4'd6,  0,1,1,0,1, 2'b01}; // scalar older
      tbl[4] = '{4'd14, 4'd1, 4'd15, 1,0,0,1,1, 2'b10}; // wrap: age_v 1, age_s 3
      tbl[5] = '{4'd0,  4'd5, 4'd1,  0,1,0,1,0, 2'b01}; // v_ena gates vector
      tbl[6] = '{4'd2,  4'd7, 4'd7,  1,0,1,0,1, 2'b01}; // tie -> scalar
      tbl[7] = '{4'd5,  4'd1, 4'd2,  0,0,0,0,1, 2'b00}; // nobody
      tbl[8] = '{4'd15, 4'd0, 4'd14, 1,0,1,0,1, 2'b01}; // wrap: age_s 1, age_v 15
      for (int i = 0; i < 9; i++) begin
         cb_tail_index = tbl[i].tail; scalar_cb_index = tbl[i].sidx;
         vector_cb_index = tbl[i].vidx;
         s_ren = tbl[i].sr; s_wen = tbl[i].sw; v_ren = tbl[i].vr; v_wen = tbl[i].vw;
         v_ena = tbl[i].ve; s_addr = 32'h1000 + i; v_addr = 32'h2000 + i;
         s_wdata = 32'h5A5A0000 + i; v_wdata = 32'hA5A50000 + i;
         s_byte_en = 4'hF; v_byte_en = 4'h3; mem_busy = 1;
         tick();
         chk($sformatf("tbl%0d_owner", i), grant_owner, tbl[i].exp);
         tick();
         mem_busy = 0; mem_rdata = 32'hC0DE0000 + i;
         tick();
         quiet();
         tick();
      end

      // Scalar-only read: grant cycle 1, data cycle 3, idle cycle 4.
      quiet(); s_ren = 1; s_addr = 32'h100; s_byte_en = 4'hF;
      tick();
      chk("sread_grant_c1", grant_owner, 2'b01);
      chk("sread_mem_ren_c1", {mem_ren, mem_addr}, {1'b1, 32'h100});
      tick();
      mem_busy = 0; mem_rdata = 32'hDEADBEEF;
      #1;
      chk("sread_done_c3", {s_busy, s_rdata, v_busy}, {1'b0, 32'hDEADBEEF, 1'b1});
      tick();
      chk("sread_idle_c4", grant_owner, 2'b00);
      quiet();
      tick();

      // Abort: scalar drops ren mid-grant.
      s_ren = 1; s_addr = 32'h200;
      tick();
      chk("abort_grant", grant_owner, 2'b01);
      s_ren = 0;
      #1;
      chk("abort_same_cycle", {mem_ren, grant_owner}, {1'b0, 2'b01});
      tick();
      chk("abort_idle", grant_owner, 2'b00);

      // Vector aborted by v_ena falling.
      v_wen = 1; v_addr = 32'h300;
      tick();
      chk("vena_grant", grant_owner, 2'b10);
      v_ena = 0;
      #1;
      chk("vena_drop_wen", mem_wen, 1'b0);
      tick();
      chk("vena_idle", grant_owner, 2'b00);
      quiet();
      tick();

      // Reset mid-grant: outputs return to idle without a clock edge.
      s_wen = 1; s_addr = 32'h400; s_wdata = 32'h12345678; s_byte_en = 4'hF;
      tick();
      chk("rst_mid_grant", grant_owner, 2'b01);
      #2 nRST = 0;
      #1;
      chk("rst_mid_owner", grant_owner, 2'b00);
      chk("rst_mid_mem", {mem_ren, mem_wen, mem_addr, mem_wdata}, 66'h0);
      chk("rst_mid_busy", {s_busy, v_busy}, 2'b11);
      m_owner = 0;
      quiet();
      @(posedge CLK); #1;
      nRST = 1;
      tick();

      // Back-to-back: both request continuously, age order alternates.
      s_ren = 1; v_ren = 1; s_addr = 32'h500; v_addr = 32'h600;
      for (int k = 0; k < 6; k++) begin
         cb_tail_index = 0;
         scalar_cb_index = (k % 2 == 0) ? 4'd1 : 4'd2;
         vector_cb_index = (k % 2 == 0) ? 4'd2 : 4'd1;
         mem_busy = 1;
         idle = 0;
         while (grant_owner == 2'b00 && idle < 5) begin
            tick();
            idle++;
         end
         chk($sformatf("b2b%0d_owner", k), grant_owner, (k % 2 == 0) ? 2'b01 : 2'b10);
         chk($sformatf("b2b%0d_idle", k), idle, 1);
         tick();
         mem_busy = 0;
         tick();
      end
      quiet();
      tick();

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 99) < 2) begin
            nRST = 0;
            m_owner = 0;
         end else begin
            nRST = 1;
         end
         v_ena = ($urandom_range(0, 9) != 0);
         cb_tail_index = $urandom; scalar_cb_index = $urandom; vector_cb_index = $urandom;
         s_ren = $urandom; s_wen = ($urandom_range(0, 3) == 0);
         v_ren = $urandom; v_wen = ($urandom_range(0, 3) == 0);
         s_addr = $urandom; v_addr = $urandom; s_wdata = $urandom; v_wdata = $urandom;
         s_byte_en = $urandom; v_byte_en = $urandom;
         mem_rdata = $urandom; mem_busy = ($urandom_range(0, 2) != 0);
         tick();
      end
      nRST = 1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
